// File: rtl/fpcmp_mc.sv
// fpcmp_mc: multi-cycle IEEE-754 binary32 compare unit.
//
// An operation is started with run=1 while idle. The predicate and operands are captured
// in that cycle and are not resampled. The operands are then classified, compared, and the
// registered result is delivered. stall stays high until the result is valid.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   run    in   1   operation request, held high until stall is seen low
//   stall  out  1   high while the result is not yet valid for the current run
//   pred   in   3   0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 UN, 7 OR
//   x      in  32   operand x (compare is "x pred y")
//   y      in  32   operand y
//   z      out  1   predicate result, held until the next completed operation
//   flags  out  5   {V, Z, O, U, I}; only V is ever set
//
// Build option: define FPCMP_DAZ_EN to treat subnormal operands as signed zero.
`timescale 1ns/1ps

module fpcmp_mc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        stall,
    input  logic [2:0]  pred,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        z,
    output logic [4:0]  flags
);

    typedef enum logic [1:0] {StIdle, StClass, StCmp, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  pred_q;
    logic [31:0] x_q, y_q;
    logic        x_nan_q, x_snan_q, x_zero_q;
    logic        y_nan_q, y_snan_q, y_zero_q;
    logic        z_q, z_d;
    logic [4:0]  flags_q, flags_d;

    logic        capture, classify, deliver;

    // Operand classification (evaluated on the captured operands)
    logic        x_nan, x_snan, x_zero;
    logic        y_nan, y_snan, y_zero;

    always_comb begin
        x_nan  = (x_q[30:23] == 8'hff) && (x_q[22:0] != 23'd0);
        y_nan  = (y_q[30:23] == 8'hff) && (y_q[22:0] != 23'd0);
        // Signaling NaN: quiet bit clear (mantissa is nonzero by x_nan)
        x_snan = x_nan && !x_q[22];
        y_snan = y_nan && !y_q[22];
`ifdef FPCMP_DAZ_EN
        // Subnormals flushed: any zero exponent counts as a signed zero
        x_zero = (x_q[30:23] == 8'd0);
        y_zero = (y_q[30:23] == 8'd0);
`else
        x_zero = (x_q[30:0] == 31'd0);
        y_zero = (y_q[30:0] == 31'd0);
`endif
    end

    // Compare and predicate evaluation
    logic unord, equal, less, both_zero;

    always_comb begin
        both_zero = x_zero_q && y_zero_q;
        unord     = x_nan_q || y_nan_q;
        equal     = both_zero || (x_q == y_q);
        less      = 1'b0;
        if (both_zero) begin
            less = 1'b0;
        end else if (x_q[31] != y_q[31]) begin
            less = x_q[31];
        end else if (!x_q[31]) begin
            less = x_q[30:0] < y_q[30:0];
        end else begin
            // Sign-magnitude: for negatives the larger magnitude is the smaller value
            less = x_q[30:0] > y_q[30:0];
        end

        z_d = 1'b0;
        unique case (pred_q)
            3'd0: z_d = !unord && equal;
            3'd1: z_d = unord || !equal;
            3'd2: z_d = !unord && less;
            3'd3: z_d = !unord && (less || equal);
            3'd4: z_d = !unord && !less && !equal;
            3'd5: z_d = !unord && !less;
            3'd6: z_d = unord;
            3'd7: z_d = !unord;
            default: z_d = 1'b0;
        endcase

        flags_d = 5'b00000;
        if (pred_q inside {3'd2, 3'd3, 3'd4, 3'd5}) begin
            flags_d[4] = unord;
        end else begin
            flags_d[4] = x_snan_q || y_snan_q;
        end
    end

    // Control FSM: next state and stage enables
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        classify = 1'b0;
        deliver  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    capture = 1'b1;
                    state_d = StClass;
                end
            end
            StClass: begin
                if (!run) begin
                    state_d = StIdle;
                end else begin
                    classify = 1'b1;
                    state_d  = StCmp;
                end
            end
            StCmp: begin
                if (!run) begin
                    state_d = StIdle;
                end else begin
                    deliver = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!run) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_q   <= 3'd0;
            x_q      <= 32'd0;
            y_q      <= 32'd0;
            x_nan_q  <= 1'b0;
            x_snan_q <= 1'b0;
            x_zero_q <= 1'b0;
            y_nan_q  <= 1'b0;
            y_snan_q <= 1'b0;
            y_zero_q <= 1'b0;
            z_q      <= 1'b0;
            flags_q  <= 5'b00000;
        end else begin
            if (capture) begin
                pred_q <= pred;
                x_q    <= x;
                y_q    <= y;
            end
            if (classify) begin
                x_nan_q  <= x_nan;
                x_snan_q <= x_snan;
                x_zero_q <= x_zero;
                y_nan_q  <= y_nan;
                y_snan_q <= y_snan;
                y_zero_q <= y_zero;
            end
            if (deliver) begin
                z_q     <= z_d;
                flags_q <= flags_d;
            end
        end
    end

    assign stall = run && (state_q != StDone);
    assign z     = z_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_fpcmp_mc.sv
// tb_fpcmp_mc: directed and randomized checks of fpcmp_mc against an ordering-key model.
`timescale 1ns/1ps

module tb_fpcmp_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        stall;
    logic [2:0]  pred = 3'd0;
    logic [31:0] x = 32'd0;
    logic [31:0] y = 32'd0;
    logic        z;
    logic [4:0]  flags;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] pool [12] = '{32'h00000000, 32'h80000000, 32'h3f800000, 32'hbf800000,
                               32'h7f800000, 32'hff800000, 32'h7fc00000, 32'h7f800001,
                               32'hffc00000, 32'h00000001, 32'h80000001, 32'h007fffff};

    fpcmp_mc u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .stall (stall),
        .pred  (pred),
        .x     (x),
        .y     (y),
        .z     (z),
        .flags (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: map each non-NaN value onto a signed integer whose order matches
    // the real-number order (both zeros map to 0), then compare integers.
    function automatic bit is_nan(input logic [31:0] b);
        return (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    endfunction

    function automatic bit is_snan(input logic [31:0] b);
        return is_nan(b) && !b[22];
    endfunction

    function automatic longint key(input logic [31:0] b);
        longint m;
        m = longint'({33'd0, b[30:0]});
`ifdef FPCMP_DAZ_EN
        if (b[30:23] == 8'd0) m = 0;
`endif
        return b[31] ? -m : m;
    endfunction

    function automatic void ref_cmp(input logic [2:0] p, input logic [31:0] a, input logic [31:0] b,
                                    output logic ez, output logic [4:0] ef);
        bit un;
        bit sig;
        longint ka;
        longint kb;
        un  = is_nan(a) || is_nan(b);
        sig = (p >= 3'd2) && (p <= 3'd5);
        ka  = key(a);
        kb  = key(b);
        case (p)
            3'd0: ez = !un && (ka == kb);
            3'd1: ez = un || (ka != kb);
            3'd2: ez = !un && (ka < kb);
            3'd3: ez = !un && (ka <= kb);
            3'd4: ez = !un && (ka > kb);
            3'd5: ez = !un && (ka >= kb);
            3'd6: ez = un;
            default: ez = !un;
        endcase
        ef = {sig ? un : (is_snan(a) || is_snan(b)), 4'b0000};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: v = pool[$urandom_range(0, 11)];
            1: v[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hff;
            2: v[30:23] = 8'(7'h3f + $urandom_range(0, 3));
            default: ;
        endcase
        return v;
    endfunction

    // One complete operation: raise run, count stall cycles (scrambling the inputs while
    // stalled), check the result in DONE, then drop run.
    task automatic do_op(input logic [2:0] p, input logic [31:0] a, input logic [31:0] b,
                         input logic ez, input logic [4:0] ef, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        pred = p;
        x    = a;
        y    = b;
        run  = 1'b1;
        #1;
        while (stall === 1'b1 && n < 8) begin
            n++;
            @(negedge clk);
            pred = 3'($urandom);
            x    = $urandom;
            y    = $urandom;
            #1;
        end
        chk({tag, "/stall_cycles"}, n, 3);
        chk({tag, "/z"}, 32'(z), 32'(ez));
        chk({tag, "/flags"}, 32'(flags), 32'(ef));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        run = 1'b0;
    endtask

    initial begin
        logic        ez;
        logic [4:0]  ef;
        logic [2:0]  rp;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        #3;
        chk("rst/z", 32'(z), 0);
        chk("rst/flags", 32'(flags), 0);
        chk("rst/stall_idle", 32'(stall), 0);
        run = 1'b1;
        #1;
        chk("rst/stall_follows_run", 32'(stall), 1);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_op(3'd0, 32'h3f800000, 32'h3f800000, 1'b1, 5'h00, "eq_one");
        do_op(3'd2, 32'h80000000, 32'h00000000, 1'b0, 5'h00, "lt_szero");
        do_op(3'd3, 32'h80000000, 32'h00000000, 1'b1, 5'h00, "le_szero");
        do_op(3'd0, 32'h80000000, 32'h00000000, 1'b1, 5'h00, "eq_szero");
        do_op(3'd2, 32'h7fc00000, 32'h3f800000, 1'b0, 5'h10, "lt_qnan");
        do_op(3'd0, 32'h7fc00000, 32'h3f800000, 1'b0, 5'h00, "eq_qnan");
        do_op(3'd6, 32'h7fc00000, 32'h3f800000, 1'b1, 5'h00, "un_qnan");
        do_op(3'd0, 32'h7f800001, 32'h3f800000, 1'b0, 5'h10, "eq_snan");
        do_op(3'd4, 32'hc0000000, 32'hbf800000, 1'b0, 5'h00, "gt_neg");
        do_op(3'd2, 32'hc0000000, 32'hbf800000, 1'b1, 5'h00, "lt_neg");
        do_op(3'd5, 32'hff800000, 32'hff800000, 1'b1, 5'h00, "ge_ninf");
`ifdef FPCMP_DAZ_EN
        do_op(3'd0, 32'h00000001, 32'h80000000, 1'b1, 5'h00, "eq_subn");
`else
        do_op(3'd0, 32'h00000001, 32'h80000000, 1'b0, 5'h00, "eq_subn");
`endif

        // Randomized cases against the model
        for (int i = 0; i < 250; i++) begin
            rp = 3'($urandom);
            ra = rand_op();
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: rb = ra ^ 32'h80000000;
                default: rb = rand_op();
            endcase
            ref_cmp(rp, ra, rb, ez, ef);
            do_op(rp, ra, rb, ez, ef, "rand");
        end

        // Abort in CMP: result registers untouched, FSM back to idle
        do_op(3'd0, 32'h3f800000, 32'h3f800000, 1'b1, 5'h00, "pre_abort");
        @(negedge clk);
        pred = 3'd6;
        x    = 32'h7fc00000;
        y    = 32'h00000000;
        run  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        #1;
        chk("abort/stall", 32'(stall), 0);
        chk("abort/z_now", 32'(z), 1);
        @(negedge clk);
        #1;
        chk("abort/z_after", 32'(z), 1);
        chk("abort/flags_after", 32'(flags), 0);
        do_op(3'd6, 32'h7fc00000, 32'h00000000, 1'b1, 5'h00, "post_abort");

        // Asynchronous reset during CMP
        do_op(3'd1, 32'h7f800001, 32'h3f800000, 1'b1, 5'h10, "pre_reset");
        @(negedge clk);
        pred = 3'd0;
        x    = 32'h00000000;
        y    = 32'h00000000;
        run  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset/z", 32'(z), 0);
        chk("areset/flags", 32'(flags), 0);
        chk("areset/stall", 32'(stall), 1);
        run = 1'b0;
        #1;
        rst_n = 1'b1;
        do_op(3'd4, 32'h3f800000, 32'hbf800000, 1'b1, 5'h00, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpcmp_mc.md
# fpcmp_mc

Multi-cycle IEEE-754 single-precision compare unit, sitting directly downstream of the serial test controller. It also serves any CPU-side FP control path. It accepts a predicate and two operands under a run/stall handshake and returns a 1-bit result plus a 5-bit exception flag vector. Internally it is a small FSM: capture, classify, compare, deliver. Outputs stay registered until the next operation.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  operation request; held high by master until stall seen low
- stall  out  1  high while result not yet valid for the current run
- pred  in  3  predicate: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 UN (unordered), 7 OR (ordered)
- x  in  32  operand x (binary32); compare is "x pred y"
- y  in  32  operand y (binary32)
- z  out  1  predicate result
- flags  out  5  {V, Z, O, U, I} exception flags; only V ever set, [3:0] always 0

## Operation
- FSM states: IDLE, CLASS, CMP, DONE.
- IDLE:
  - If run=1, register pred/x/y and go to CLASS. Operands are not resampled afterwards.
- CLASS:
  - Decode each operand: sign, exponent all-ones/zero, mantissa zero.
  - Produce isNaN, isSNaN (mantissa[22]=0, nonzero mantissa) and isZero.
  - Go to CMP.
- CMP:
  - Unordered = either operand NaN.
  - Equal = (both zero, sign ignored) or (bit patterns identical).
  - Less:
    - Signs differ, not both zero: less = x negative.
    - Both positive: less = x[30:0] < y[30:0], unsigned 31-bit.
    - Both negative: less = x[30:0] > y[30:0].
  - Evaluate pred from these and register z and flags. Go to DONE.
- Predicate results when unordered: EQ/LT/LE/GT/GE/OR give 0; NE/UN give 1.
- Invalid flag (V):
  - LT/LE/GT/GE (signaling): V=1 if either operand is any NaN.
  - EQ/NE/UN/OR (quiet): V=1 only if either operand is SNaN.
- DONE:
  - Stay while run=1.
  - On run=0, go to IDLE.
- Abort: run=0 in CLASS or CMP returns to IDLE without updating z/flags.
- stall = run & (state != DONE), combinational. It is therefore high in the same cycle run rises.
- z and flags change only on the CMP->DONE transition.

## Timing
- Reset (rst_n low, any cycle, asynchronous):
  - State forced to IDLE; z=0, flags=5'b00000.
  - stall follows run (high if run high), since state != DONE.
- Latency:
  - run rises in cycle 0; stall is high in cycles 0, 1, 2.
  - In cycle 3 (DONE), stall=0 and z/flags are valid. The master may sample them on that edge.
- Master drops run one or more cycles after seeing stall=0. A new run may start the cycle after IDLE is re-entered.
- Back-to-back: with run held high, no new operation starts. The master must present run=0 for at least one cycle between operations.
- Operand or pred changes while stall=1 are ignored.

## Configuration
- FPCMP_DAZ_EN defined:
  - Subnormal operands (exponent 0, mantissa nonzero) are treated as signed zero in CLASS and CMP.
  - 0x00000001 EQ 0x80000000 gives 1.
  - No flag is raised for DAZ.
- Undefined: subnormals compare by exact value per IEEE-754.

## Test plan
- pred=0 (EQ), x=y=0x3F800000, run held:
  - stall high exactly 3 cycles, then z=1, flags=0x00.
- Signed zero, x=0x80000000, y=0x00000000:
  - pred=2 (LT) gives z=0.
  - pred=3 (LE) gives z=1.
  - pred=0 (EQ) gives z=1. flags=0x00 in all cases.
- NaN:
  - x=0x7FC00000, y=0x3F800000: pred=2 gives z=0, flags=0x10; pred=0 gives z=0, flags=0x00; pred=6 gives z=1, flags=0x00.
  - x=0x7F800001, pred=0 gives z=0, flags=0x10.
- Negatives and infinity:
  - x=0xC0000000 (-2), y=0xBF800000 (-1): pred=4 (GT) gives z=0; pred=2 (LT) gives z=1.
  - x=y=0xFF800000: pred=5 (GE) gives z=1.
- Abort and reset:
  - After a completed op with z=1, start a new op and drop run in cycle 2. Required: stall low, z stays 1, FSM back in IDLE.
  - Pulse rst_n low mid-CMP: z=0, flags=0 immediately, without waiting for a clock edge.
- Subnormals: x=0x00000001, y=0x80000000, pred=0.
  - z=1 with FPCMP_DAZ_EN defined.
  - z=0 without FPCMP_DAZ_EN.
